// File: rtl/xor_bind_mon_pkg.sv
// Shared types, constants and the expected-value helper for the XOR bind monitor.
package xor_bind_mon_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } mon_state_e;

  localparam int unsigned MODE_XOR   = 0;
  localparam int unsigned MODE_XNOR  = 1;
  localparam int unsigned FILL_CNT_W = 4;

  // One bit of the reference result; mode=1 inverts for XNOR datapaths.
  function automatic logic exp_val(input logic a, input logic b, input logic mode);
    return (a ^ b) ^ mode;
  endfunction

endpackage

// File: rtl/xor_bind_mon_delay.sv
// Expected-value delay line with per-stage valid bits; pure wires when LATENCY is 0.
module xor_bind_mon_delay
  import xor_bind_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  if (LATENCY == 0) begin : g_wire
    logic unused_c;
    assign unused_c = ^{clk, rst_n, flush_i};
    assign data_o   = data_i;
    assign valid_o  = valid_i;
  end else begin : g_pipe
    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0]            valid_q;

    // Flush kills every in-flight sample, including the one entering now.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        data_q[0]  <= data_i;
        valid_q[0] <= valid_i & ~flush_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1] & ~flush_i;
        end
      end
    end

    assign data_o  = data_q[LATENCY-1];
    assign valid_o = valid_q[LATENCY-1];
  end

endmodule

// File: rtl/xor_bind_monitor.sv
// Bindable multi-channel checker: compares c against a delayed a^b (or ~(a^b)) reference.
module xor_bind_monitor
  import xor_bind_mon_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned MODE        = 0,
  parameter int unsigned STOP_ON_ERR = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clear,
  input  logic [CHANNELS*WIDTH-1:0]    a,
  input  logic [CHANNELS*WIDTH-1:0]    b,
  input  logic [CHANNELS*WIDTH-1:0]    c,
  output logic                         err,
  output logic                         err_sticky,
  output logic [CNT_W-1:0]             err_count,
  output logic [CHANNELS-1:0]          mismatch_mask,
  output logic [$clog2(CHANNELS):0]    first_ch,
  output logic                         first_valid,
  output logic [1:0]                   state_o
);

  localparam int unsigned BUS_W   = CHANNELS * WIDTH;
  localparam int unsigned FCH_W   = $clog2(CHANNELS) + 1;
  localparam bit          INVERT  = (MODE == MODE_XNOR);
  localparam mon_state_e  INIT_ST = (LATENCY == 0) ? CHECK : FILL;

  logic [BUS_W-1:0]      exp_c;
  logic [BUS_W-1:0]      exp_dly;
  logic                  vld_dly;
  logic                  cmp_c;
  logic [CHANNELS-1:0]   mm_c;
  logic                  any_c;
  logic [FCH_W-1:0]      lowest_c;

  mon_state_e            state_q, state_d;
  logic [FILL_CNT_W-1:0] fill_q, fill_d;
  logic                  err_q, err_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic [FCH_W-1:0]      fch_q, fch_d;
  logic                  fvalid_q, fvalid_d;

  for (genvar i = 0; i < BUS_W; i++) begin : g_exp
    assign exp_c[i] = exp_val(a[i], b[i], INVERT);
  end

  xor_bind_mon_delay #(
    .WIDTH   (BUS_W),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clear),
    .data_i  (exp_c),
    .valid_i (en),
    .data_o  (exp_dly),
    .valid_o (vld_dly)
  );

  assign cmp_c = (state_q == CHECK) && vld_dly;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_cmp
    assign mm_c[ch] = cmp_c && (c[ch*WIDTH +: WIDTH] != exp_dly[ch*WIDTH +: WIDTH]);
  end

  assign any_c = |mm_c;

  // Descending scan so the lowest failing lane is the last one written.
  always_comb begin
    lowest_c = '0;
    for (int unsigned ch = CHANNELS; ch > 0; ch--) begin
      if (mm_c[ch-1]) lowest_c = FCH_W'(ch - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    err_d    = any_c;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    mask_d   = mm_c;
    fch_d    = fch_q;
    fvalid_d = fvalid_q;

    case (state_q)
      FILL: begin
        if (en) begin
          fill_d = fill_q + FILL_CNT_W'(1);
          if (fill_q == FILL_CNT_W'(LATENCY - 1)) state_d = CHECK;
        end
      end
      CHECK: begin
        if ((STOP_ON_ERR != 0) && any_c) state_d = HALT;
      end
      HALT: begin
        err_d  = 1'b0;
        mask_d = mask_q;
      end
      default: state_d = INIT_ST;
    endcase

    if (any_c) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (!fvalid_q) begin
        fch_d    = lowest_c;
        fvalid_d = 1'b1;
      end
    end

    // Clear wins over any mismatch seen in the same cycle.
    if (clear) begin
      state_d  = INIT_ST;
      fill_d   = '0;
      err_d    = 1'b0;
      sticky_d = 1'b0;
      cnt_d    = '0;
      mask_d   = '0;
      fch_d    = '0;
      fvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT_ST;
      fill_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      mask_q   <= '0;
      fch_q    <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      fch_q    <= fch_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign err           = err_q;
  assign err_sticky    = sticky_q;
  assign err_count     = cnt_q;
  assign mismatch_mask = mask_q;
  assign first_ch      = fch_q;
  assign first_valid   = fvalid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_xor_bind_monitor.sv
// Directed scoreboard bench: one 1x1 zero-latency monitor and two 4x8 latency-3 monitors.
module tb_xor_bind_monitor;
  import xor_bind_mon_pkg::*;

  localparam logic [31:0] CORR_ALL = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       err;
    logic [3:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        en0 = 1'b0, clear0 = 1'b0, a0 = 1'b0, b0 = 1'b0, c0 = 1'b0;
  logic        err0, sticky0, fv0;
  logic [15:0] cnt0;
  logic [0:0]  mask0, fch0;
  logic [1:0]  st0;

  logic        en = 1'b0, clear = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        err1, sticky1, fv1, err2, sticky2, fv2;
  logic [2:0]  cnt1, fch1, fch2;
  logic [15:0] cnt2;
  logic [3:0]  mask1, mask2;
  logic [1:0]  st1, st2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] hist[$];

  always #5 clk = ~clk;

  xor_bind_monitor #(.WIDTH(1), .CHANNELS(1), .LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .clear(clear0), .a(a0), .b(b0), .c(c0),
    .err(err0), .err_sticky(sticky0), .err_count(cnt0), .mismatch_mask(mask0),
    .first_ch(fch0), .first_valid(fv0), .state_o(st0));

  xor_bind_monitor #(.WIDTH(8), .CHANNELS(4), .LATENCY(3), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .c(c),
    .err(err1), .err_sticky(sticky1), .err_count(cnt1), .mismatch_mask(mask1),
    .first_ch(fch1), .first_valid(fv1), .state_o(st1));

  xor_bind_monitor #(.WIDTH(8), .CHANNELS(4), .LATENCY(3), .STOP_ON_ERR(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .c(c),
    .err(err2), .err_sticky(sticky2), .err_count(cnt2), .mismatch_mask(mask2),
    .first_ch(fch2), .first_valid(fv2), .state_o(st2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("sb_err", 32'(err1), 32'(x.err));
      chk("sb_mask", 32'(mask1), 32'(x.mask));
    end
  endtask

  // One cycle: check the previous compare, then drive this cycle; c is a^b from 3 steps ago ^ corr.
  task automatic step(input logic e, input logic clr, input logic [31:0] corr,
                      input logic xe, input logic [3:0] xm);
    logic [31:0] av, bv, cg;
    @(negedge clk);
    pop_check();
    av = $urandom;
    bv = $urandom;
    hist.push_back(av ^ bv);
    cg = (hist.size() >= 4) ? hist[hist.size()-4] : 32'h0;
    a = av;
    b = bv;
    c = cg ^ corr;
    en = e;
    clear = clr;
    sb.push_back('{err: xe, mask: xm});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_err"}, 32'(err1), 0);
    chk({tag, "_sticky"}, 32'(sticky1), 0);
    chk({tag, "_cnt"}, 32'(cnt1), 0);
    chk({tag, "_mask"}, 32'(mask1), 0);
    chk({tag, "_fv"}, 32'(fv1), 0);
    chk({tag, "_fch"}, 32'(fch1), 0);
    chk({tag, "_st1"}, 32'(st1), 32'(FILL));
    chk({tag, "_st2"}, 32'(st2), 32'(FILL));
    chk({tag, "_sticky2"}, 32'(sticky2), 0);
    chk({tag, "_st0"}, 32'(st0), 32'(CHECK));
  endtask

  task automatic pulse_reset();
    en = 1'b0;
    clear = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    // Zero-latency lane over all four operand combinations.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("u0_err", 32'(err0), 0);
      a0 = i[0];
      b0 = i[1];
      c0 = i[0] ^ i[1];
      en0 = 1'b1;
    end
    @(negedge clk);
    chk("u0_err_last", 32'(err0), 0);
    chk("u0_cnt", 32'(cnt0), 0);
    chk("u0_state", 32'(st0), 32'(CHECK));

    // Fill, then a single-lane fault on channel 1.
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("fill_done", 32'(st1), 32'(CHECK));
    step(1'b1, 1'b0, 32'h0000_0100, 1'b1, 4'b0010);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("inj_cnt", 32'(cnt1), 1);
    chk("inj_fch", 32'(fch1), 1);
    chk("inj_fv", 32'(fv1), 1);
    chk("inj_sticky", 32'(sticky1), 1);

    // Clear coincident with a mismatch, then en toggling 1,0,1,1 under corrupt c.
    step(1'b1, 1'b1, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    chk("clr_cnt", 32'(cnt1), 0);
    chk("clr_sticky", 32'(sticky1), 0);
    chk("clr_fv", 32'(fv1), 0);
    chk("clr_st1", 32'(st1), 32'(FILL));
    chk("clr_st2", 32'(st2), 32'(FILL));
    step(1'b0, 1'b0, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    chk("bubble_st", 32'(st1), 32'(CHECK));

    // Ten failing compare cycles against a 3-bit counter.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, CORR_ALL, 1'b1, 4'hF);
      if (i == 3) chk("sat_mid", 32'(cnt1), 3);
    end
    chk("sat_cnt", 32'(cnt1), 7);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("sat_hold", 32'(cnt1), 7);
    chk("sat_fch", 32'(fch1), 0);

    // Stop-on-error: channels 2 and 3 fail together, then channel 0 keeps failing.
    step(1'b1, 1'b1, 32'h0, 1'b0, 4'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 32'h0101_0000, 1'b1, 4'b1100);
    step(1'b1, 1'b0, 32'h0000_0001, 1'b1, 4'b0001);
    chk("halt_st", 32'(st2), 32'(HALT));
    chk("halt_err", 32'(err2), 1);
    chk("halt_mask", 32'(mask2), 32'h0000_000C);
    chk("halt_fch", 32'(fch2), 2);
    chk("halt_cnt", 32'(cnt2), 1);
    step(1'b1, 1'b0, 32'h0000_0001, 1'b1, 4'b0001);
    chk("halt_err0", 32'(err2), 0);
    chk("halt_cnt_frz", 32'(cnt2), 1);
    chk("halt_st_frz", 32'(st2), 32'(HALT));
    chk("halt_sticky", 32'(sticky2), 1);
    chk("halt_fch_frz", 32'(fch2), 2);
    chk("run_cnt", 32'(cnt1), 2);
    chk("run_fch", 32'(fch1), 2);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("halt_err0b", 32'(err2), 0);

    // Reset mid-check, then mid-fill; refill must precede any compare.
    pulse_reset();
    chk_idle("rst_chk");
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    pulse_reset();
    chk_idle("rst_fill");
    repeat (3) step(1'b1, 1'b0, CORR_ALL, 1'b0, 4'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0);
    step(1'b1, 1'b0, CORR_ALL, 1'b1, 4'hF);
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0);
    chk("refill_cnt", 32'(cnt1), 1);
    chk("refill_st", 32'(st1), 32'(CHECK));
    @(negedge clk);
    pop_check();
    chk("u0_cnt_end", 32'(cnt0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
